// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared FSM type and reset constants for the interrupt controller
package int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } int_state_e;

  localparam logic [5:0] ACK_STATE_DEFAULT = 6'd40;
  localparam logic       MASK_RST_BIT      = 1'b1;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - 2-flop synchroniser plus rising-edge detector for one request line
module irq_sync (
  input  logic clk,
  input  logic rstn,
  input  logic irq,
  output logic rise
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [2:0] fill;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      fill <= '0;
    end else begin
      s1   <= irq;
      s2   <= s1;
      prev <= s2;
      fill <= {fill[1:0], 1'b1};
    end
  end

  // A line already high at reset release is not an event: edges only count once
  // both s2 and prev hold genuinely sampled values rather than reset zeros.
  assign rise = s2 & ~prev & fill[2];

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - latches, masks and prioritises request lines into INT
module interrupt_controller
  import int_pkg::*;
#(
  parameter int              N_IRQ     = 4,
  parameter int              ST_W      = 6,
  parameter logic [ST_W-1:0] ACK_STATE = ST_W'(ACK_STATE_DEFAULT),
  localparam int             ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic [ST_W-1:0]  st,
  output logic             INT,
  output logic [ID_W-1:0]  int_id,
  output logic [N_IRQ-1:0] pending
);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic [ID_W-1:0]  winner;
  logic             ack;
  int_state_e       state;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync u_sync (
      .clk  (clk),
      .rstn (rstn),
      .irq  (irq[g]),
      .rise (rise[g])
    );
  end

  assign eligible = pending & ~mask;
  assign ack      = (st == ACK_STATE);

  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (state == REQ && ack) clr[int_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      INT     <= 1'b0;
      int_id  <= '0;
      pending <= '0;
      mask    <= {N_IRQ{MASK_RST_BIT}};
    end else begin
      // A new edge on the source being acknowledged must survive the clear.
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_in;
      case (state)
        IDLE: begin
          if (|eligible) begin
            int_id <= winner;
            INT    <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            INT   <= 1'b0;
            state <= SERV;
          end
        end
        SERV: begin
          if (!ack) state <= IDLE;
        end
        default: begin
          INT   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
